// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT accelerator host-side blocks.
// Dataset sizes give the number of final-layer feature words per run.
package gat_pkg;

    localparam int GAT_NEW_FEATURE_WIDTH = 32;

    localparam int CORA_NUM_SUBGRAPHS        = 2708;
    localparam int CORA_NUM_FEATURE_OUT      = 16;
    localparam int CORA_NEW_FEATURE_DEPTH    =
        CORA_NUM_SUBGRAPHS * CORA_NUM_FEATURE_OUT;

    localparam int CITESEER_NUM_SUBGRAPHS     = 3327;
    localparam int CITESEER_NUM_FEATURE_OUT   = 16;
    localparam int CITESEER_NEW_FEATURE_DEPTH =
        CITESEER_NUM_SUBGRAPHS * CITESEER_NUM_FEATURE_OUT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } drain_state_t;

endpackage

// File: rtl/gat_feat_drain_fifo.sv
// First-word-fall-through return buffer between the feature BRAM and the stream.
// Head data is valid whenever o_empty is low; pop is ignored when empty.
module gat_feat_drain_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_rd    = i_pop & ~o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_rd) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({i_push, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gat_feat_drain.sv
// Drains the final-layer feature BRAM onto an AXI4-Stream master after the
// accelerator finishes, absorbing BRAM latency and downstream backpressure.
module gat_feat_drain
    import gat_pkg::*;
#(
    parameter int NEW_FEATURE_WIDTH  = GAT_NEW_FEATURE_WIDTH,
    parameter int NEW_FEATURE_DEPTH  = CORA_NEW_FEATURE_DEPTH,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int BRAM_RD_LATENCY    = 2,
    parameter int FIFO_DEPTH         = BRAM_RD_LATENCY + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          drain_busy,
    output logic                          drain_done
);

    localparam int CNT_W = NEW_FEATURE_ADDR_W + 1;
    localparam int LAT   = BRAM_RD_LATENCY;
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    drain_state_t r_state;
    drain_state_t w_next;

    logic                          r_gat_ready_q;
    logic [CNT_W-1:0]              r_rd_idx;
    logic [CNT_W-1:0]              r_sent_cnt;
    logic [LAT-1:0]                r_vld_sr;
    logic [NEW_FEATURE_ADDR_W+1:0] r_addrb;
    logic [NEW_FEATURE_ADDR_W+1:0] w_addrb;
    logic [FCW-1:0]                w_fifo_count;
    logic [FCW-1:0]                w_inflight;
    logic [NEW_FEATURE_WIDTH-1:0]  w_fifo_data;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic                          w_start;
    logic                          w_issue;
    logic                          w_push;
    logic                          w_beat;
    logic                          w_last_rd;
    logic                          w_last_beat;

    assign w_start     = gat_ready & ~r_gat_ready_q;
    assign w_push      = r_vld_sr[LAT-1];
    assign w_beat      = ~w_fifo_empty & m_axis_tready;
    assign w_last_rd   = (r_rd_idx == CNT_W'(NEW_FEATURE_DEPTH - 1));
    assign w_last_beat = (r_sent_cnt == CNT_W'(NEW_FEATURE_DEPTH - 1));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + FCW'(r_vld_sr[i]);
        end
    end

    // Reads in flight already own a FIFO slot, so the buffer cannot overflow.
    assign w_issue = (r_state == ST_RUN) &&
                     ((w_fifo_count + w_inflight) < FCW'(FIFO_DEPTH));

    assign w_addrb = w_issue ?
        {r_rd_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00} : r_addrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_RUN;
            ST_RUN:   if (w_issue && w_last_rd) w_next = ST_FLUSH;
            ST_FLUSH: if (w_beat && w_last_beat) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        drain_busy = (r_state == ST_RUN) || (r_state == ST_FLUSH);
        drain_done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gat_ready_q <= 1'b0;
            r_rd_idx      <= '0;
            r_sent_cnt    <= '0;
            r_vld_sr      <= '0;
            r_addrb       <= '0;
        end else begin
            r_gat_ready_q <= gat_ready;
            r_vld_sr      <= (r_vld_sr << 1) | LAT'(w_issue);
            r_addrb       <= w_addrb;
            if ((r_state == ST_IDLE) && w_start) begin
                r_rd_idx   <= '0;
                r_sent_cnt <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_idx <= r_rd_idx + CNT_W'(1);
                end
                if (w_beat) begin
                    r_sent_cnt <= r_sent_cnt + CNT_W'(1);
                end
            end
        end
    end

    gat_feat_drain_fifo #(
        .WIDTH (NEW_FEATURE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (feat_bram_dout),
        .i_pop   (w_beat),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full)
    );

    assign feat_bram_addrb = w_addrb;
    assign m_axis_tvalid   = ~w_fifo_empty;
    // Stale buffer contents are masked so the bus idles at zero.
    assign m_axis_tdata    = m_axis_tvalid ? w_fifo_data : '0;
    assign m_axis_tlast    = w_last_beat & m_axis_tvalid;

endmodule

// File: tb/tb_gat_feat_drain.sv
// Bench for gat_feat_drain: three instances (read latency 1, 2 and 4) share
// stimulus; each checks its stream against a simple word-order model.
module tb_gat_feat_drain;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic gat_ready = 1'b0;
    logic tready = 1'b0;

    int cyc = 0;
    int run_id = 0;
    int start_cyc = 0;
    bit contig = 1'b0;
    bit stall_chk = 1'b0;

    int n_asserts = 0;
    int n_fail = 0;

    logic [2:0] done_v;
    logic [2:0] tvalid_v;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int FD = L + 2;

        logic [4:0]  addrb;
        logic [31:0] dout;
        logic [31:0] tdata;
        logic        tvalid;
        logic        tlast;
        logic        busy;
        logic        done;
        logic [31:0] pipe [L];

        int          n = 0;
        int          dones = 0;
        int          last_addr = -1;
        int          last_beat = 0;
        int          my_run = -1;
        bit          first_seen = 1'b0;
        bit          hold = 1'b0;
        logic [31:0] hold_data = '0;
        logic        hold_last = 1'b0;
        logic [4:0]  alog [$];

        gat_feat_drain #(
            .NEW_FEATURE_WIDTH (32),
            .NEW_FEATURE_DEPTH (DEPTH),
            .BRAM_RD_LATENCY   (L)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .gat_ready       (gat_ready),
            .feat_bram_addrb (addrb),
            .feat_bram_dout  (dout),
            .m_axis_tdata    (tdata),
            .m_axis_tvalid   (tvalid),
            .m_axis_tready   (tready),
            .m_axis_tlast    (tlast),
            .drain_busy      (busy),
            .drain_done      (done)
        );

        assign done_v[g]   = done;
        assign tvalid_v[g] = tvalid;

        // BRAM model: mem[i] = 0xA000_0000 + i, L cycles address to data.
        always @(posedge clk) begin
            pipe[0] <= 32'hA000_0000 + {29'd0, addrb[4:2]};
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign dout = pipe[L-1];

        always @(negedge rst_n) begin
            #1;
            chk($sformatf("L%0d_rst_tvalid", L), 64'(tvalid), 64'd0);
            chk($sformatf("L%0d_rst_tlast", L), 64'(tlast), 64'd0);
            chk($sformatf("L%0d_rst_tdata", L), 64'(tdata), 64'd0);
            chk($sformatf("L%0d_rst_busy", L), 64'(busy), 64'd0);
            chk($sformatf("L%0d_rst_done", L), 64'(done), 64'd0);
            chk($sformatf("L%0d_rst_addrb", L), 64'(addrb), 64'd0);
        end

        always @(negedge clk) begin
            if (my_run != run_id) begin
                n = 0;
                dones = 0;
                first_seen = 1'b0;
                last_addr = -1;
                alog.delete();
                hold = 1'b0;
                my_run = run_id;
            end
            if (rst_n) begin
                if (hold) begin
                    chk($sformatf("L%0d_hold_valid", L), 64'(tvalid), 64'd1);
                    chk($sformatf("L%0d_hold_data", L), 64'(tdata),
                        64'(hold_data));
                    chk($sformatf("L%0d_hold_last", L), 64'(tlast),
                        64'(hold_last));
                end
                hold = tvalid & ~tready;
                hold_data = tdata;
                hold_last = tlast;
                if (busy && int'(addrb) != last_addr) begin
                    alog.push_back(addrb);
                    last_addr = int'(addrb);
                end
                if (busy) begin
                    chk($sformatf("L%0d_occupancy", L),
                        64'((alog.size() - n) <= FD), 64'd1);
                end
                if (tvalid && !first_seen) begin
                    chk($sformatf("L%0d_first_tvalid", L), 64'(cyc - start_cyc),
                        64'(L + 2));
                    first_seen = 1'b1;
                end
                if (tvalid && tready) begin
                    if (contig && n > 0) begin
                        chk($sformatf("L%0d_gap", L), 64'(cyc), 64'(last_beat + 1));
                    end
                    chk($sformatf("L%0d_tdata", L), 64'(tdata),
                        64'(32'hA000_0000 + n));
                    chk($sformatf("L%0d_tlast", L), 64'(tlast),
                        (n == DEPTH - 1) ? 64'd1 : 64'd0);
                    n++;
                    last_beat = cyc;
                end
                if (stall_chk && (cyc == start_cyc + 12 || cyc == start_cyc + 20)) begin
                    chk($sformatf("L%0d_stall_reads", L), 64'(alog.size()), 64'(FD));
                    chk($sformatf("L%0d_stall_addr", L), 64'(last_addr),
                        64'(4 * (FD - 1)));
                    chk($sformatf("L%0d_stall_valid", L), 64'(tvalid), 64'd1);
                    chk($sformatf("L%0d_stall_beats", L), 64'(n), 64'd0);
                end
                if (done) begin
                    chk($sformatf("L%0d_done_once", L), 64'(dones), 64'd0);
                    dones++;
                    chk($sformatf("L%0d_beats", L), 64'(n), 64'(DEPTH));
                    chk($sformatf("L%0d_reads", L), 64'(alog.size()), 64'(DEPTH));
                    foreach (alog[i]) begin
                        chk($sformatf("L%0d_addr%0d", L, i), 64'(alog[i]),
                            64'(4 * i));
                    end
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic start_run();
        gat_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        gat_ready = 1'b1;
        start_cyc = cyc;
        run_id++;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        logic [2:0] seen = '0;
        for (int k = 0; k < budget && seen != 3'b111; k++) begin
            @(negedge clk);
            seen = seen | done_v;
            @(posedge clk);
            #1;
            if (rnd) tready = ($urandom_range(0, 99) < 40);
        end
        chk("done_all", 64'(seen), 64'd7);
    endtask

    initial begin
        int b;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // full-rate drain
        #1 tready = 1'b1;
        contig = 1'b1;
        start_run();
        wait_done(100, 1'b0);

        // random backpressure
        contig = 1'b0;
        start_run();
        wait_done(400, 1'b1);

        // stalled sink: credit must stop reads
        tready = 1'b0;
        stall_chk = 1'b1;
        start_run();
        repeat (21) @(posedge clk);
        #1 tready = 1'b1;
        stall_chk = 1'b0;
        wait_done(100, 1'b0);

        // gat_ready toggles mid-run are ignored
        contig = 1'b1;
        start_run();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 gat_ready = ~gat_ready;
        end
        wait_done(100, 1'b0);
        repeat (30) @(posedge clk);

        // fresh rise gives a second full run
        start_run();
        wait_done(100, 1'b0);

        // reset after three beats, then drain again from word 0
        start_run();
        b = 0;
        for (int k = 0; k < 100 && b < 3; k++) begin
            @(negedge clk);
            if (tvalid_v[1] && tready) b++;
        end
        chk("beats_before_reset", 64'(b), 64'd3);
        #2;
        rst_n = 1'b0;
        gat_ready = 1'b0;
        run_id++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_run();
        wait_done(100, 1'b0);

        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gat_feat_drain.md
# gat_feat_drain

Read-side drain engine for the final-layer feature BRAM. After the accelerator reports completion, it walks the new-feature buffer through the byte-addressed `feat_bram_addrb`/`feat_bram_dout` read port and emits every word, in address order, on an AXI4-Stream master toward the host DMA. It sits beside `gat_top_wrapper` in the block design and absorbs BRAM read latency and stream backpressure without losing or duplicating words.

## Interface

- NEW_FEATURE_WIDTH, 32: BRAM word and stream data width.
- NEW_FEATURE_DEPTH, 43328: words to drain per run (NUM_SUBGRAPHS*NUM_FEATURE_OUT for CORA).
- NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH): word-address width.
- BRAM_RD_LATENCY, 2: cycles from address to valid `feat_bram_dout`, range 1..4.
- FIFO_DEPTH, BRAM_RD_LATENCY+2: return-buffer entries.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- gat_ready  in  1  accelerator-done level; a rising edge starts a drain.
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address (word index << 2, bits [1:0] = 0).
- feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data.
- m_axis_tdata  out  NEW_FEATURE_WIDTH  feature word.
- m_axis_tvalid  out  1  data valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  high on word NEW_FEATURE_DEPTH-1.
- drain_busy  out  1  high from start until last word accepted.
- drain_done  out  1  one-cycle pulse after last beat accepted.

## Operation

- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: gat_ready rising edge (registered previous value) -> RUN; rd_idx=0, sent_cnt=0.
- RUN: issue a read in any cycle where credit = FIFO_DEPTH - (fifo_count + inflight) > 0; issuing drives addrb={rd_idx,2'b00}, pushes a 1 into a BRAM_RD_LATENCY-deep valid shift register, increments rd_idx. After issuing index NEW_FEATURE_DEPTH-1 -> FLUSH.
- FLUSH: no new reads; wait until sent_cnt reaches NEW_FEATURE_DEPTH -> DONE.
- DONE: pulse drain_done for one cycle -> IDLE.
- Returned data: when shift-register tail is 1, `feat_bram_dout` is written into the FIFO that cycle. Credit scheme guarantees the FIFO never overflows; overflow is a design error (assertion).
- Stream: tvalid = FIFO non-empty; tdata = FIFO head; beat on tvalid&tready pops and increments sent_cnt; tlast = (sent_cnt == NEW_FEATURE_DEPTH-1) & tvalid.
- Once asserted, tvalid holds with stable tdata/tlast until accepted.
- gat_ready edges while not IDLE are ignored; a new drain needs gat_ready to fall and rise again.
- Counters: rd_idx and sent_cnt are NEW_FEATURE_ADDR_W+1 bits; no wrap within a run.

## Timing

- Reset values: addrb=0, tdata=0, tvalid=0, tlast=0, drain_busy=0, drain_done=0, FSM=IDLE, FIFO empty, shift register cleared.
- Reset mid-run: all state clears asynchronously; in-flight returns are discarded; no partial tlast.
- drain_busy rises the cycle after the sampled gat_ready edge.
- First tvalid: edge + 1 + BRAM_RD_LATENCY + 1 cycles (FIFO write, registered head).
- Throughput: one word/cycle sustained with tready held high; FIFO_DEPTH >= latency+2 covers the credit round trip.
- tready low: reads stop once credit reaches 0; resuming tready restores 1 word/cycle within BRAM_RD_LATENCY+1 cycles.
- A simultaneous FIFO push and pop leaves the count unchanged.
- drain_done pulses the cycle after the tlast beat; drain_busy falls in the same cycle.

## Structure

- `gat_pkg`: NEW_FEATURE_WIDTH and depth constants per dataset (CORA/CITESEER), FSM state enum `drain_state_t`.
- Sub-module `gat_feat_drain_fifo`: synchronous FWFT FIFO, parameterized width and depth, exposing count, full and empty.
- Top holds the FSM, edge detect, address counter, valid shift register, credit logic and tlast generation.

## Test plan

- Use NEW_FEATURE_DEPTH=8 and BRAM_RD_LATENCY=2 with a BRAM model holding mem[i]=0xA000_0000+i. Raise gat_ready with tready=1 -> 8 beats on consecutive cycles with data 0xA0000000..0xA0000007, tlast only on the 8th, drain_done pulses once, and addrb sweeps 0x00..0x1C.
- Random tready with 40% duty -> same 8 words in order with no gaps or duplicates; tdata stays stable while tvalid&!tready; FIFO count never exceeds FIFO_DEPTH.
- Hold tready=0 for 20 cycles after start -> exactly FIFO_DEPTH reads issued and then addrb freezes; releasing tready delivers all 8 words.
- Toggle gat_ready during RUN -> no restart and exactly 8 beats; a fresh rise after DONE -> a second full run.
- Assert rst_n=0 after 3 beats -> all outputs return to reset values immediately; a new start after release drains from word 0.
- Sweep BRAM_RD_LATENCY=1 and 4 -> ordered data, and first tvalid at edge+3 and edge+6 respectively.
